// File: rtl/sdp_erdma_ig_if.sv
// Request and context-queue channels of the SDP read-DMA ingress; both use valid/ready handshakes.
interface sdp_erdma_ig_if;
  logic        dma_rd_req_pvld;
  logic        dma_rd_req_prdy;
  logic [78:0] dma_rd_req_pd;
  logic        ig2cq_pvld;
  logic        ig2cq_prdy;
  logic [15:0] ig2cq_pd;

  modport master (
    output dma_rd_req_pvld, dma_rd_req_pd, ig2cq_pvld, ig2cq_pd,
    input  dma_rd_req_prdy, ig2cq_prdy
  );

  modport slave (
    input  dma_rd_req_pvld, dma_rd_req_pd, ig2cq_pvld, ig2cq_pd,
    output dma_rd_req_prdy, ig2cq_prdy
  );
endinterface

// File: rtl/sdp_erdma_ig.sv
// SDP element-wise read-DMA ingress: walks a surface, one DMA read + one context entry per burst, first valid the cycle after op_load.
// DMA and context channels transfer in the same cycle or not at all; SDP_ERDMA_IG_PERF_EN adds the ig_stall_cnt output.
module sdp_erdma_ig #(
  parameter int MAX_BURST = 8
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rstn,
  input  logic           op_load,
  input  logic [63:0]    reg2dp_base_addr,
  input  logic [12:0]    reg2dp_width_m1,
  input  logic [12:0]    reg2dp_height_m1,
  input  logic [31:0]    reg2dp_line_stride,
  sdp_erdma_ig_if.master ig_if,
  output logic           op_busy,
  output logic           op_done
`ifdef SDP_ERDMA_IG_PERF_EN
  ,
  output logic [31:0]    ig_stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  typedef struct packed {
    logic [14:0] size_m1;
    logic [63:0] addr;
  } dma_req_t;

  typedef struct packed {
    logic       last_req;
    logic       last_line;
    logic       line_end;
    logic [4:0] rsvd;
    logic [7:0] size_m1;
  } cq_ent_t;

  localparam logic [13:0] MAX_B = 14'(MAX_BURST);

  state_t      state_q, state_d;
  logic [63:0] line_addr_q, line_addr_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [12:0] atom_cnt_q, atom_cnt_d;
  logic [12:0] line_cnt_q, line_cnt_d;
  logic        op_done_q, op_done_d;
  logic [12:0] width_m1_q, height_m1_q;
  logic [26:0] stride_q;

  logic        run, load, accept, line_end, last_line;
  logic [13:0] remaining, burst, size_m1;
  logic [63:0] next_line_addr;
  dma_req_t    req;
  cq_ent_t     ent;
  logic        unused_cfg_lsbs;

  assign unused_cfg_lsbs = ^{reg2dp_base_addr[4:0], reg2dp_line_stride[4:0]};

  assign run    = (state_q == RUN);
  assign load   = (state_q == IDLE) && op_load;
  assign accept = run && ig_if.dma_rd_req_prdy && ig_if.ig2cq_prdy;

  assign remaining      = {1'b0, width_m1_q} - {1'b0, atom_cnt_q} + 14'd1;
  assign burst          = (remaining > MAX_B) ? MAX_B : remaining;
  assign size_m1        = burst - 14'd1;
  assign line_end       = (burst == remaining);
  assign last_line      = (line_cnt_q == height_m1_q);
  assign next_line_addr = line_addr_q + {32'd0, stride_q, 5'd0};

  // Each valid only waits on the opposite ready, so neither side can transfer alone.
  assign ig_if.dma_rd_req_pvld = run && ig_if.ig2cq_prdy;
  assign ig_if.ig2cq_pvld      = run && ig_if.dma_rd_req_prdy;
  assign ig_if.dma_rd_req_pd   = req;
  assign ig_if.ig2cq_pd        = ent;
  assign op_busy               = run;
  assign op_done               = op_done_q;

  always_comb begin
    req = '0;
    ent = '0;
    if (run) begin
      req.size_m1   = {1'b0, size_m1};
      req.addr      = cur_addr_q;
      ent.last_req  = line_end && last_line;
      ent.last_line = last_line;
      ent.line_end  = line_end;
      ent.size_m1   = size_m1[7:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    cur_addr_d  = cur_addr_q;
    atom_cnt_d  = atom_cnt_q;
    line_cnt_d  = line_cnt_q;
    op_done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_load) begin
          state_d     = RUN;
          line_addr_d = {reg2dp_base_addr[63:5], 5'd0};
          cur_addr_d  = {reg2dp_base_addr[63:5], 5'd0};
          atom_cnt_d  = '0;
          line_cnt_d  = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (line_end) begin
            atom_cnt_d  = '0;
            line_cnt_d  = line_cnt_q + 13'd1;
            line_addr_d = next_line_addr;
            cur_addr_d  = next_line_addr;
            if (last_line) begin
              state_d   = IDLE;
              op_done_d = 1'b1;
            end
          end else begin
            atom_cnt_d = atom_cnt_q + burst[12:0];
            cur_addr_d = cur_addr_q + {45'd0, burst, 5'd0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      cur_addr_q  <= '0;
      atom_cnt_q  <= '0;
      line_cnt_q  <= '0;
      op_done_q   <= 1'b0;
      width_m1_q  <= '0;
      height_m1_q <= '0;
      stride_q    <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      cur_addr_q  <= cur_addr_d;
      atom_cnt_q  <= atom_cnt_d;
      line_cnt_q  <= line_cnt_d;
      op_done_q   <= op_done_d;
      if (load) begin
        width_m1_q  <= reg2dp_width_m1;
        height_m1_q <= reg2dp_height_m1;
        stride_q    <= reg2dp_line_stride[31:5];
      end
    end
  end

`ifdef SDP_ERDMA_IG_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load)
      stall_cnt_d = '0;
    else if (run && !accept && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) stall_cnt_q <= '0;
    else                  stall_cnt_q <= stall_cnt_d;
  end

  assign ig_stall_cnt = stall_cnt_q;
`endif

endmodule
